// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart block: register map, status/control bit
// positions, FSM state encodings and the divisor reset value.
package io_uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam int ST_RXV     = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_RXOVR   = 3;
  localparam int ST_FRERR   = 4;
  localparam int ST_TXBUSY  = 5;

  localparam int CT_RXIE = 0;
  localparam int CT_TXIE = 1;
  localparam int CT_EN   = 2;

  localparam logic [7:0] DIV_RST = 8'd15;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // A divisor of 0 would give a 1-clock bit; it is treated as 1 instead.
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/io_uart_if.sv
// Core-side I/O port bus of the UART; signal directions are named from the
// UART's point of view.
interface io_uart_if;
  logic [7:0] io_addr_i;
  logic [7:0] io_data_i;
  logic       io_we_i;
  logic [7:0] io_data_o;
  logic       irq_o;

  modport master (output io_addr_i, io_data_i, io_we_i, input  io_data_o, irq_o);
  modport slave  (input  io_addr_i, io_data_i, io_we_i, output io_data_o, irq_o);
endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted only
// when a pop happens in the same cycle.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full_o  = (r_cnt == CNT_FULL);
  assign empty_o = (r_cnt == '0);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | pop_i);
  assign dout_o  = r_mem[r_rp];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/io_uart.sv
// Port-mapped 8N1 UART: DATA/STATUS/CTRL/DIV registers, TX FIFO, single RX
// buffer with overrun/framing flags and a registered level interrupt.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         TX_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  io_uart_if.slave   bus,
  input  logic       uart_rx_i,
  output logic       uart_tx_o
);
  logic [7:0] w_off, w_div, w_rdata, w_status, w_fifo_dout;
  logic       w_hit, w_wr, w_wr_data, w_wr_stat, w_en, w_full, w_empty, w_txbusy;
  logic       w_pop_rx, w_load;
  logic [2:0] r_ctrl;
  logic [7:0] r_div, r_rxbuf;
  logic       r_rxv, r_rxovr, r_frerr, r_irq;

  assign w_off     = bus.io_addr_i - BASE_ADDR;
  assign w_hit     = (w_off[7:2] == 6'd0);
  assign w_wr      = bus.io_we_i & w_hit;
  assign w_wr_data = w_wr & (w_off[1:0] == OFF_DATA);
  assign w_wr_stat = w_wr & (w_off[1:0] == OFF_STATUS);
  assign w_en      = r_ctrl[CT_EN];
  assign w_div     = eff_div(r_div);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl <= 3'd0;
      r_div  <= DIV_RST;
    end else begin
      if (w_wr && w_off[1:0] == OFF_CTRL) r_ctrl <= bus.io_data_i[2:0];
      if (w_wr && w_off[1:0] == OFF_DIV)  r_div  <= bus.io_data_i;
    end
  end

  // ---- TX: FIFO feeding a shift register; counters reload from DIV per bit
  tx_state_e  r_tx_state, w_tx_state_n;
  logic [7:0] r_tx_cnt, w_tx_cnt_n, r_tx_sh, w_tx_sh_n;
  logic [2:0] r_tx_bit, w_tx_bit_n;
  logic       r_tx_line, w_tx_line, w_tx_pop;

  io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_wr_data), .pop_i(w_tx_pop),
    .din_i(bus.io_data_i), .dout_o(w_fifo_dout), .full_o(w_full), .empty_o(w_empty)
  );

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_sh_n    = r_tx_sh;
    w_tx_bit_n   = r_tx_bit;
    w_tx_pop     = 1'b0;
    w_tx_line    = 1'b1;
    case (r_tx_state)
      TX_IDLE: if (!w_empty) begin
        w_tx_pop = 1'b1; w_tx_sh_n = w_fifo_dout; w_tx_cnt_n = w_div; w_tx_state_n = TX_START;
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (r_tx_cnt == 8'd0) begin
          w_tx_state_n = TX_DATA; w_tx_cnt_n = w_div; w_tx_bit_n = 3'd0;
        end else w_tx_cnt_n = r_tx_cnt - 8'd1;
      end
      TX_DATA: begin
        w_tx_line = r_tx_sh[0];
        if (r_tx_cnt == 8'd0) begin
          w_tx_cnt_n = w_div; w_tx_sh_n = {1'b0, r_tx_sh[7:1]}; w_tx_bit_n = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_n = TX_STOP;
        end else w_tx_cnt_n = r_tx_cnt - 8'd1;
      end
      TX_STOP: begin
        if (r_tx_cnt == 8'd0) w_tx_state_n = TX_IDLE;
        else                  w_tx_cnt_n   = r_tx_cnt - 8'd1;
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
    if (!w_en) begin
      w_tx_state_n = TX_IDLE; w_tx_pop = 1'b0; w_tx_line = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_state <= TX_IDLE; r_tx_cnt <= 8'd0; r_tx_sh <= 8'd0; r_tx_bit <= 3'd0; r_tx_line <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n; r_tx_cnt <= w_tx_cnt_n; r_tx_sh <= w_tx_sh_n;
      r_tx_bit <= w_tx_bit_n; r_tx_line <= w_tx_line;
    end
  end

  assign uart_tx_o = r_tx_line;
  assign w_txbusy  = (r_tx_state != TX_IDLE);

  // ---- RX: start edges only count once the synchronized line was seen high
  rx_state_e  r_rx_state, w_rx_state_n;
  logic [7:0] r_rx_cnt, w_rx_cnt_n, r_rx_sh, w_rx_sh_n;
  logic [2:0] r_rx_bit, w_rx_bit_n;
  logic [1:0] r_rx_vld;
  logic       r_rx_s1, r_rx_s2, r_rx_prev, w_rx_done, w_rx_ferr;

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_sh_n    = r_rx_sh;
    w_rx_bit_n   = r_rx_bit;
    w_rx_done    = 1'b0;
    w_rx_ferr    = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_state_n = RX_START; w_rx_cnt_n = (w_div - 8'd1) >> 1;
      end
      RX_START: begin
        if (r_rx_cnt == 8'd0) begin
          if (r_rx_s2) w_rx_state_n = RX_IDLE;
          else begin w_rx_state_n = RX_DATA; w_rx_cnt_n = w_div; w_rx_bit_n = 3'd0; end
        end else w_rx_cnt_n = r_rx_cnt - 8'd1;
      end
      RX_DATA: begin
        if (r_rx_cnt == 8'd0) begin
          w_rx_sh_n = {r_rx_s2, r_rx_sh[7:1]}; w_rx_cnt_n = w_div; w_rx_bit_n = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
        end else w_rx_cnt_n = r_rx_cnt - 8'd1;
      end
      RX_STOP: begin
        if (r_rx_cnt == 8'd0) begin
          w_rx_state_n = RX_IDLE; w_rx_done = r_rx_s2; w_rx_ferr = ~r_rx_s2;
        end else w_rx_cnt_n = r_rx_cnt - 8'd1;
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
    if (!w_en) begin
      w_rx_state_n = RX_IDLE; w_rx_done = 1'b0; w_rx_ferr = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_vld <= 2'b00; r_rx_prev <= 1'b0;
      r_rx_state <= RX_IDLE; r_rx_cnt <= 8'd0; r_rx_sh <= 8'd0; r_rx_bit <= 3'd0;
    end else begin
      r_rx_s1 <= uart_rx_i; r_rx_s2 <= r_rx_s1; r_rx_vld <= {r_rx_vld[0], 1'b1};
      r_rx_prev <= r_rx_vld[1] & r_rx_s2;
      r_rx_state <= w_rx_state_n; r_rx_cnt <= w_rx_cnt_n; r_rx_sh <= w_rx_sh_n;
      r_rx_bit <= w_rx_bit_n;
    end
  end

  // ---- Flags: a hardware set in the same cycle as a W1C clear wins
  assign w_pop_rx = w_wr_stat & bus.io_data_i[ST_RXV];
  assign w_load   = w_rx_done & (~r_rxv | w_pop_rx);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rxbuf <= 8'd0; r_rxv <= 1'b0; r_rxovr <= 1'b0; r_frerr <= 1'b0; r_irq <= 1'b0;
    end else begin
      if (w_load) r_rxbuf <= r_rx_sh;
      if (w_load)        r_rxv <= 1'b1;
      else if (w_pop_rx) r_rxv <= 1'b0;
      if (w_rx_done && r_rxv && !w_pop_rx)           r_rxovr <= 1'b1;
      else if (w_wr_stat && bus.io_data_i[ST_RXOVR]) r_rxovr <= 1'b0;
      if (w_rx_ferr)                                 r_frerr <= 1'b1;
      else if (w_wr_stat && bus.io_data_i[ST_FRERR]) r_frerr <= 1'b0;
      r_irq <= (r_ctrl[CT_RXIE] & r_rxv) | (r_ctrl[CT_TXIE] & w_empty & ~w_txbusy);
    end
  end

  always_comb begin
    w_status             = 8'd0;
    w_status[ST_RXV]     = r_rxv;
    w_status[ST_TXFULL]  = w_full;
    w_status[ST_TXEMPTY] = w_empty;
    w_status[ST_RXOVR]   = r_rxovr;
    w_status[ST_FRERR]   = r_frerr;
    w_status[ST_TXBUSY]  = w_txbusy;
  end

  always_comb begin
    w_rdata = 8'd0;
    if (w_hit) begin
      case (w_off[1:0])
        OFF_DATA:   w_rdata = r_rxbuf;
        OFF_STATUS: w_rdata = w_status;
        OFF_CTRL:   w_rdata = {5'd0, r_ctrl};
        default:    w_rdata = r_div;
      endcase
    end
  end

  assign bus.io_data_o = w_rdata;
  assign bus.irq_o     = r_irq;
endmodule

// File: tb/tb_io_uart.sv
// Directed plus randomized bench for io_uart; serial frames are generated and
// decoded with a bit-period model of the 8N1 line format.
module tb_io_uart;
  localparam logic [7:0] A_DATA = 8'h10, A_STAT = 8'h11, A_CTRL = 8'h12, A_DIV = 8'h13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic tx;
  int   total = 0;
  int   bad   = 0;

  io_uart_if bus();

  io_uart #(.BASE_ADDR(8'h10), .TX_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .uart_rx_i(rx), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_addr_i = a; bus.io_data_i = d; bus.io_we_i = 1'b1;
    @(negedge clk);
    bus.io_we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.io_addr_i = a; bus.io_we_i = 1'b0;
    #1;
    d = bus.io_data_o;
  endtask

  // Drive one serial frame: start 0, data LSB first, chosen stop level.
  task automatic rx_drive(input logic [7:0] b, input logic stopb, input int p);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = fr[i];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
  endtask

  // Decode one frame from uart_tx_o, sampling near the middle of each bit.
  task automatic tx_recv(input int p, input int budget, output logic [7:0] b,
                         output logic got, output logic stop_ok);
    got = 1'b0; b = 8'd0; stop_ok = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (tx === 1'b0) got = 1'b1;
    end
    if (got) begin
      repeat (p / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (p) @(negedge clk);
        b[k] = tx;
      end
      repeat (p) @(negedge clk);
      stop_ok = tx;
    end
  endtask

  initial begin
    logic [7:0] s, d, b, rb, g, pat;
    logic       got, sok, seen;
    int         p, dv, idx, lows;
    logic [7:0] q[$];

    bus.io_addr_i = 8'h00; bus.io_data_i = 8'h00; bus.io_we_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_irq", bus.irq_o, 1'b0);
    rd(A_STAT, s); chk8("rst_status", s, 8'h04);
    rd(A_CTRL, s); chk8("rst_ctrl", s, 8'h00);
    rd(A_DIV, s);  chk8("rst_div", s, 8'h0F);
    rd(A_DATA, s); chk8("rst_data", s, 8'h00);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);

    // TX frame timing, cycle by cycle
    wr(A_DIV, 8'd3); wr(A_CTRL, 8'h04);
    pat = 8'hA5;
    wr(A_DATA, pat);
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      idx = (n - 2) / 4;
      if (n < 2 || idx >= 9) chk1("tx_a5_line", tx, 1'b1);
      else if (idx == 0)     chk1("tx_a5_start", tx, 1'b0);
      else                   chk1("tx_a5_bit", tx, pat[idx-1]);
      rd(A_STAT, s);
      chk1("tx_a5_busy", s[5], (n <= 40));
    end

    // RX frame, RXV and interrupt latency
    wr(A_CTRL, 8'h05);
    rx_drive(8'h3C, 1'b1, 4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); rd(A_STAT, s);
      if (s[0]) seen = 1'b1;
    end
    chk1("rx_3c_rxv", seen, 1'b1);
    chk1("rx_irq_lag", bus.irq_o, 1'b0);
    @(negedge clk); #1;
    chk1("rx_irq_rise", bus.irq_o, 1'b1);
    rd(A_DATA, s); chk8("rx_3c_data", s, 8'h3C);

    // Overrun keeps the old byte; W1C pops and clears
    rx_drive(8'h55, 1'b1, 4);
    repeat (4) @(negedge clk);
    rd(A_STAT, s); chk8("ovr_status", s, 8'h0D);
    rd(A_DATA, s); chk8("ovr_data", s, 8'h3C);
    wr(A_STAT, 8'h09);
    rd(A_STAT, s); chk8("ovr_cleared", s, 8'h04);
    repeat (2) @(negedge clk); #1;
    chk1("irq_drop", bus.irq_o, 1'b0);

    // Framing error and glitch rejection
    rx_drive(8'hC3, 1'b0, 4);
    repeat (4) @(negedge clk);
    rd(A_STAT, s); chk8("frerr_status", s, 8'h14);
    wr(A_STAT, 8'h10);
    rd(A_STAT, s); chk8("frerr_clear", s, 8'h04);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(A_STAT, s); chk8("glitch_status", s, 8'h04);

    // FIFO fill with EN=0, then drain
    wr(A_CTRL, 8'h00);
    @(negedge clk);
    bus.io_addr_i = A_DATA; bus.io_we_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.io_data_i = 8'(i);
      @(negedge clk);
    end
    bus.io_we_i = 1'b0;
    rd(A_STAT, s); chk8("fifo_full", s, 8'h02);
    wr(A_CTRL, 8'h04);
    for (int i = 1; i <= 4; i++) begin
      tx_recv(4, 200, g, got, sok);
      chk1("drain_got", got, 1'b1);
      chk8("drain_byte", g, 8'(i));
      chk1("drain_stop", sok, 1'b1);
    end
    tx_recv(4, 100, g, got, sok);
    chk1("drain_no_extra", got, 1'b0);
    rd(A_STAT, s); chk8("drain_empty", s, 8'h04);
    wr(8'h14, 8'hFF);
    rd(A_CTRL, s); chk8("unmapped_wr", s, 8'h04);

    // EN=0 mid-frame forces the line high and TX idle
    wr(A_DATA, 8'h00);
    repeat (8) @(negedge clk);
    wr(A_CTRL, 8'h00);
    chk1("en_off_inflight", tx, 1'b0);
    @(negedge clk);
    chk1("en_off_tx", tx, 1'b1);
    rd(A_STAT, s); chk1("en_off_busy", s[5], 1'b0);

    // Randomized loopback-style traffic against the frame model
    for (int it = 0; it < 8; it++) begin
      dv = int'($urandom_range(0, 5));
      b  = 8'($urandom);
      rb = 8'($urandom);
      p  = ((dv == 0) ? 1 : dv) + 1;
      wr(A_DIV, 8'(dv)); wr(A_CTRL, 8'h04);
      q.push_back(b);
      wr(A_DATA, b);
      tx_recv(p, 50, g, got, sok);
      d = q.pop_front();
      chk1("rnd_tx_got", got, 1'b1);
      chk8("rnd_tx_byte", g, d);
      chk1("rnd_tx_stop", sok, 1'b1);
      repeat (2 * p) @(negedge clk);
      rx_drive(rb, 1'b1, p);
      repeat (3) @(negedge clk);
      rd(A_STAT, s); chk1("rnd_rx_rxv", s[0], 1'b1);
      rd(A_DATA, s); chk8("rnd_rx_byte", s, rb);
      wr(A_STAT, 8'h01);
    end

    // Reset mid-frame
    wr(A_DIV, 8'd3); wr(A_CTRL, 8'h04);
    wr(A_DATA, 8'hAA); wr(A_DATA, 8'hBB); wr(A_DATA, 8'hCC);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk1("rst_mid_tx", tx, 1'b1);
    rd(A_STAT, s); chk8("rst_mid_status", s, 8'h04);
    rd(A_CTRL, s); chk8("rst_mid_ctrl", s, 8'h00);
    rd(A_DIV, s);  chk8("rst_mid_div", s, 8'h0F);
    @(negedge clk); rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk8("rst_mid_quiet", 8'(lows), 8'd0);
    rd(8'h20, s); chk8("unmapped_rd", s, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
